// File: rtl/mem_access_unit.sv
// Load/store engine: one op at a time on a 64-bit valid/ack data bus, aligns stores, extends loads.
// Latency: accept -> bus request next cycle -> resp_valid the cycle after ack; stall holds the pipe until then.
module mem_access_unit #(
  parameter int XLEN   = 64,
  parameter int ADDR_W = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  input  logic                req_write,
  input  logic [1:0]          req_size,
  input  logic                req_unsigned,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [XLEN-1:0]     req_wdata,
  output logic                req_ready,
  output logic                stall,
  output logic                resp_valid,
  output logic [XLEN-1:0]     resp_data,
  output logic                resp_misalign,
  output logic                dreq_valid,
  output logic                dreq_write,
  output logic [ADDR_W-1:0]   dreq_addr,
  output logic [XLEN/8-1:0]   dreq_strobe,
  output logic [XLEN-1:0]     dreq_data,
  input  logic                dresp_valid,
  input  logic [XLEN-1:0]     dresp_data
);

  localparam int NB    = XLEN / 8;
  localparam int OFF_W = $clog2(NB);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t             state_q, state_d;
  logic [1:0]         size_q, size_d;
  logic               uns_q, uns_d;
  logic [OFF_W-1:0]   off_q, off_d;
  logic               dreq_valid_q, dreq_valid_d;
  logic               dreq_write_q, dreq_write_d;
  logic [ADDR_W-1:0]  dreq_addr_q, dreq_addr_d;
  logic [NB-1:0]      dreq_strobe_q, dreq_strobe_d;
  logic [XLEN-1:0]    dreq_data_q, dreq_data_d;
  logic               resp_valid_q, resp_valid_d;
  logic               resp_misalign_q, resp_misalign_d;
  logic [XLEN-1:0]    resp_data_q, resp_data_d;

  logic [OFF_W-1:0]   req_off;
  logic               misalign;
  logic [NB-1:0]      lanes;
  logic [XLEN-1:0]    raw;
  logic [XLEN-1:0]    load_ext;

  assign req_off = req_addr[OFF_W-1:0];

  always_comb begin
    misalign = 1'b0;
    case (req_size)
      2'd0:    misalign = 1'b0;
      2'd1:    misalign = req_addr[0];
      2'd2:    misalign = |req_addr[1:0];
      default: misalign = |req_addr[2:0];
    endcase
  end

  // Contiguous run of (1 << size) lane enables starting at lane 0
  always_comb begin
    lanes = '0;
    for (int i = 0; i < NB; i++) begin
      lanes[i] = (i < (1 << req_size));
    end
  end

  always_comb begin
    raw      = dresp_data >> {off_q, 3'b000};
    load_ext = raw;
    case (size_q)
      2'd0:    load_ext = uns_q ? {{(XLEN-8){1'b0}},  raw[7:0]}
                                : {{(XLEN-8){raw[7]}}, raw[7:0]};
      2'd1:    load_ext = uns_q ? {{(XLEN-16){1'b0}},   raw[15:0]}
                                : {{(XLEN-16){raw[15]}}, raw[15:0]};
      2'd2:    load_ext = uns_q ? {{(XLEN-32){1'b0}},   raw[31:0]}
                                : {{(XLEN-32){raw[31]}}, raw[31:0]};
      default: load_ext = raw;
    endcase
  end

  always_comb begin
    state_d         = state_q;
    size_d          = size_q;
    uns_d           = uns_q;
    off_d           = off_q;
    dreq_valid_d    = dreq_valid_q;
    dreq_write_d    = dreq_write_q;
    dreq_addr_d     = dreq_addr_q;
    dreq_strobe_d   = dreq_strobe_q;
    dreq_data_d     = dreq_data_q;
    resp_valid_d    = resp_valid_q;
    resp_misalign_d = resp_misalign_q;
    resp_data_d     = resp_data_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (misalign) begin
            state_d         = DONE;
            resp_valid_d    = 1'b1;
            resp_misalign_d = 1'b1;
            resp_data_d     = '0;
          end else begin
            state_d       = WAIT;
            size_d        = req_size;
            uns_d         = req_unsigned;
            off_d         = req_off;
            dreq_valid_d  = 1'b1;
            dreq_write_d  = req_write;
            dreq_addr_d   = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            dreq_strobe_d = req_write ? (lanes << req_off) : '0;
            dreq_data_d   = req_write ? (req_wdata << {req_off, 3'b000}) : '0;
          end
        end
      end
      WAIT: begin
        if (dresp_valid) begin
          state_d         = DONE;
          dreq_valid_d    = 1'b0;
          resp_valid_d    = 1'b1;
          resp_misalign_d = 1'b0;
          resp_data_d     = dreq_write_q ? '0 : load_ext;
        end
      end
      default: begin
        state_d         = IDLE;
        resp_valid_d    = 1'b0;
        resp_misalign_d = 1'b0;
        resp_data_d     = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= IDLE;
      size_q          <= '0;
      uns_q           <= 1'b0;
      off_q           <= '0;
      dreq_valid_q    <= 1'b0;
      dreq_write_q    <= 1'b0;
      dreq_addr_q     <= '0;
      dreq_strobe_q   <= '0;
      dreq_data_q     <= '0;
      resp_valid_q    <= 1'b0;
      resp_misalign_q <= 1'b0;
      resp_data_q     <= '0;
    end else begin
      state_q         <= state_d;
      size_q          <= size_d;
      uns_q           <= uns_d;
      off_q           <= off_d;
      dreq_valid_q    <= dreq_valid_d;
      dreq_write_q    <= dreq_write_d;
      dreq_addr_q     <= dreq_addr_d;
      dreq_strobe_q   <= dreq_strobe_d;
      dreq_data_q     <= dreq_data_d;
      resp_valid_q    <= resp_valid_d;
      resp_misalign_q <= resp_misalign_d;
      resp_data_q     <= resp_data_d;
    end
  end

  assign req_ready     = (state_q == IDLE);
  // Low in DONE so the stage advances in the same cycle the result appears
  assign stall         = ((state_q == IDLE) && req_valid) || (state_q == WAIT);
  assign resp_valid    = resp_valid_q;
  assign resp_data     = resp_data_q;
  assign resp_misalign = resp_misalign_q;
  assign dreq_valid    = dreq_valid_q;
  assign dreq_write    = dreq_write_q;
  assign dreq_addr     = dreq_addr_q;
  assign dreq_strobe   = dreq_strobe_q;
  assign dreq_data     = dreq_data_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: each task drives one scenario and checks cycle-exact outputs.
module tb_mem_access_unit;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        req_ready;
  logic        stall;
  logic        resp_valid;
  logic [63:0] resp_data;
  logic        resp_misalign;
  logic        dreq_valid;
  logic        dreq_write;
  logic [63:0] dreq_addr;
  logic [7:0]  dreq_strobe;
  logic [63:0] dreq_data;
  logic        dresp_valid;
  logic [63:0] dresp_data;

  int checks   = 0;
  int failures = 0;

  mem_access_unit #(.XLEN(64), .ADDR_W(64)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_write(req_write), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .stall(stall),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_misalign(resp_misalign),
    .dreq_valid(dreq_valid), .dreq_write(dreq_write), .dreq_addr(dreq_addr),
    .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
    .dresp_valid(dresp_valid), .dresp_data(dresp_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid = 0; req_write = 0; req_size = 0; req_unsigned = 0;
    req_addr = 0; req_wdata = 0; dresp_valid = 0; dresp_data = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 0;
    #12;
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL rst_req_ready got=%0h exp=1", req_ready); end
    checks++; if (dreq_valid !== 1'b0) begin failures++; $display("FAIL rst_dreq_valid got=%0h exp=0", dreq_valid); end
    checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL rst_resp_valid got=%0h exp=0", resp_valid); end
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL rst_stall got=%0h exp=0", stall); end
    checks++; if (dreq_strobe !== 8'h00 || dreq_addr !== 64'h0) begin failures++; $display("FAIL rst_dreq_regs got=%h/%h exp=0/0", dreq_strobe, dreq_addr); end
    @(negedge clk);
    rst = 1;
    step();
  endtask

  task automatic test_load_byte();
    req_valid = 1; req_write = 0; req_size = 2'd0; req_unsigned = 0; req_addr = 64'h1003;
    #1;
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL lb_stall_c0 got=%0h exp=1", stall); end
    step();
    req_valid = 0; req_addr = 64'h0;
    dresp_valid = 1; dresp_data = 64'h0000_0000_8000_0000;
    #1;
    checks++; if (dreq_valid !== 1'b1) begin failures++; $display("FAIL lb_dreq_valid got=%0h exp=1", dreq_valid); end
    checks++; if (dreq_addr !== 64'h1000) begin failures++; $display("FAIL lb_dreq_addr got=%h exp=1000", dreq_addr); end
    checks++; if (dreq_strobe !== 8'h00) begin failures++; $display("FAIL lb_strobe got=%h exp=00", dreq_strobe); end
    checks++; if (dreq_write !== 1'b0) begin failures++; $display("FAIL lb_write got=%0h exp=0", dreq_write); end
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL lb_stall_c1 got=%0h exp=1", stall); end
    step();
    dresp_valid = 0; dresp_data = 0;
    #1;
    checks++; if (resp_valid !== 1'b1) begin failures++; $display("FAIL lb_resp_valid got=%0h exp=1", resp_valid); end
    checks++; if (resp_data !== 64'hFFFF_FFFF_FFFF_FF80) begin failures++; $display("FAIL lb_resp_data got=%h exp=ffffffffffffff80", resp_data); end
    checks++; if (resp_misalign !== 1'b0) begin failures++; $display("FAIL lb_misalign got=%0h exp=0", resp_misalign); end
    checks++; if (dreq_valid !== 1'b0 || stall !== 1'b0 || req_ready !== 1'b0) begin failures++; $display("FAIL lb_done_ctrl got=%0h%0h%0h exp=000", dreq_valid, stall, req_ready); end
    step();
    checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin failures++; $display("FAIL lb_back_idle got=%0h%0h exp=01", resp_valid, req_ready); end
  endtask

  task automatic test_store_half();
    req_valid = 1; req_write = 1; req_size = 2'd1; req_addr = 64'h2006; req_wdata = 64'h0000_0000_0000_BEEF;
    step();
    idle_inputs();
    #1;
    checks++; if (dreq_strobe !== 8'hC0) begin failures++; $display("FAIL sh_strobe got=%h exp=c0", dreq_strobe); end
    checks++; if (dreq_data[63:48] !== 16'hBEEF) begin failures++; $display("FAIL sh_data got=%h exp=beef", dreq_data[63:48]); end
    checks++; if (dreq_write !== 1'b1 || dreq_valid !== 1'b1) begin failures++; $display("FAIL sh_write got=%0h%0h exp=11", dreq_write, dreq_valid); end
    checks++; if (dreq_addr !== 64'h2000) begin failures++; $display("FAIL sh_addr got=%h exp=2000", dreq_addr); end
    dresp_valid = 1; dresp_data = 64'hDEAD_BEEF_DEAD_BEEF;
    step();
    dresp_valid = 0;
    #1;
    checks++; if (resp_valid !== 1'b1 || resp_data !== 64'h0) begin failures++; $display("FAIL sh_resp got=%0h/%h exp=1/0", resp_valid, resp_data); end
    step();
  endtask

  task automatic test_misalign();
    req_valid = 1; req_write = 0; req_size = 2'd2; req_addr = 64'h3002;
    #1;
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL ma_stall_c0 got=%0h exp=1", stall); end
    step();
    idle_inputs();
    #1;
    checks++; if (resp_valid !== 1'b1 || resp_misalign !== 1'b1) begin failures++; $display("FAIL ma_resp got=%0h%0h exp=11", resp_valid, resp_misalign); end
    checks++; if (dreq_valid !== 1'b0) begin failures++; $display("FAIL ma_dreq_c1 got=%0h exp=0", dreq_valid); end
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL ma_stall_c1 got=%0h exp=0", stall); end
    step();
    checks++; if (dreq_valid !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 1'b1) begin failures++; $display("FAIL ma_c2 got=%0h%0h%0h exp=001", dreq_valid, resp_valid, req_ready); end
  endtask

  task automatic test_delayed_ack();
    req_valid = 1; req_write = 1; req_size = 2'd3; req_addr = 64'h5000; req_wdata = 64'h1122_3344_5566_7788;
    step();
    // keep a different request on the inputs while busy: it must be ignored
    req_addr = 64'h7008; req_wdata = 64'hAAAA_AAAA_AAAA_AAAA; req_write = 0;
    for (int c = 1; c <= 5; c++) begin
      if (c == 5) begin
        req_valid = 0; dresp_valid = 1;
      end
      #1;
      checks++; if (dreq_valid !== 1'b1 || stall !== 1'b1) begin failures++; $display("FAIL da_busy_c%0d got=%0h%0h exp=11", c, dreq_valid, stall); end
      checks++; if (dreq_addr !== 64'h5000 || dreq_strobe !== 8'hFF || dreq_data !== 64'h1122_3344_5566_7788 || dreq_write !== 1'b1)
        begin failures++; $display("FAIL da_stable_c%0d got=%h/%h/%h/%0h exp=5000/ff/1122334455667788/1", c, dreq_addr, dreq_strobe, dreq_data, dreq_write); end
      checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL da_early_resp_c%0d got=%0h exp=0", c, resp_valid); end
      step();
    end
    idle_inputs();
    #1;
    checks++; if (resp_valid !== 1'b1 || stall !== 1'b0 || dreq_valid !== 1'b0) begin failures++; $display("FAIL da_c6 got=%0h%0h%0h exp=100", resp_valid, stall, dreq_valid); end
    step();
    dresp_valid = 1; dresp_data = 64'hFFFF_FFFF_FFFF_FFFF;
    step();
    dresp_valid = 0;
    #1;
    checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0 || dreq_valid !== 1'b0 || stall !== 1'b0 || resp_data !== 64'h0)
      begin failures++; $display("FAIL da_stray_ack got=%0h%0h%0h%0h/%h exp=1000/0", req_ready, resp_valid, dreq_valid, stall, resp_data); end
  endtask

  task automatic test_word_load();
    logic [63:0] exp_tab [2];
    exp_tab[0] = 64'h0000_0000_F000_0001;
    exp_tab[1] = 64'hFFFF_FFFF_F000_0001;
    for (int k = 0; k < 2; k++) begin
      req_valid = 1; req_write = 0; req_size = 2'd2; req_unsigned = (k == 0); req_addr = 64'h4004;
      step();
      idle_inputs();
      dresp_valid = 1; dresp_data = 64'hF000_0001_1234_5678;
      step();
      dresp_valid = 0;
      #1;
      checks++; if (resp_valid !== 1'b1 || resp_data !== exp_tab[k]) begin failures++; $display("FAIL wl_%0d got=%0h/%h exp=1/%h", k, resp_valid, resp_data, exp_tab[k]); end
      step();
    end
  endtask

  task automatic test_reset_mid_wait();
    req_valid = 1; req_write = 0; req_size = 2'd3; req_addr = 64'h6000;
    step();
    idle_inputs();
    #1;
    checks++; if (dreq_valid !== 1'b1) begin failures++; $display("FAIL rw_pre got=%0h exp=1", dreq_valid); end
    #1;
    rst = 0;
    #1;
    checks++; if (dreq_valid !== 1'b0 || stall !== 1'b0 || resp_valid !== 1'b0) begin failures++; $display("FAIL rw_async got=%0h%0h%0h exp=000", dreq_valid, stall, resp_valid); end
    @(negedge clk);
    rst = 1;
    step();
    checks++; if (req_ready !== 1'b1 || dreq_valid !== 1'b0) begin failures++; $display("FAIL rw_idle got=%0h%0h exp=10", req_ready, dreq_valid); end
  endtask

  initial begin
    test_reset();
    test_load_byte();
    test_store_half();
    test_misalign();
    test_delayed_ack();
    test_word_load();
    test_reset_mid_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
